// File: rtl/oscilo_pkg.sv
// oscilo_pkg
// Shared types and constants for the oscilloscope dump path.
//   dumper_state_t : sequencer states of sample_dumper
//   hs_state_t     : states of the UART byte handshake (uart_byte_tx_hs)
//   HEADER_BYTE    : first byte of every dump frame
//   TX_IDLE_LEVEL  : level of the UART busy flag (tx_active) when the UART is free
package oscilo_pkg;

  localparam logic [7:0] HEADER_BYTE   = 8'hA5;
  localparam logic       TX_IDLE_LEVEL = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEND,
    ST_WBUSY,
    ST_WDONE,
    ST_RD,
    ST_LAT,
    ST_CSUM,
    ST_DONE
  } dumper_state_t;

  typedef enum logic [1:0] {
    HS_SEND,
    HS_WBUSY,
    HS_WDONE
  } hs_state_t;

endpackage

// File: rtl/uart_byte_tx_hs.sv
// uart_byte_tx_hs
// Moves one byte through the UART start/busy handshake. The sequencer holds
// byte_valid while it wants the byte sent (tx_data already stable); this block
// waits for the UART to be free, pulses tx_start once, waits for the UART to go
// busy and then free again, and reports completion with a one-cycle byte_done.
// Ports:
//   clk_50mhz  in  system clock, rising edge
//   reset      in  synchronous, active-high
//   byte_valid in  sequencer wants the current byte sent
//   tx_active  in  UART busy flag
//   tx_start   out registered one-cycle start pulse to the UART
//   byte_done  out combinational pulse: UART has finished the byte
module uart_byte_tx_hs
  import oscilo_pkg::*;
(
  input  logic clk_50mhz,
  input  logic reset,
  input  logic byte_valid,
  input  logic tx_active,
  output logic tx_start,
  output logic byte_done
);

  hs_state_t state_q, state_d;
  logic      tx_start_q, tx_start_d;

  // Next-state logic. HS_SEND doubles as the idle state: a byte is only
  // launched when the UART is free, so a UART that is still busy from
  // elsewhere holds us here without a start pulse. byte_done is taken
  // straight from tx_active so the sequencer can react in the same cycle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    byte_done  = 1'b0;
    case (state_q)
      HS_SEND: begin
        if (byte_valid && (tx_active == TX_IDLE_LEVEL)) begin
          tx_start_d = 1'b1;
          state_d    = HS_WBUSY;
        end
      end
      HS_WBUSY: begin
        if (tx_active != TX_IDLE_LEVEL) begin
          state_d = HS_WDONE;
        end
      end
      HS_WDONE: begin
        if (tx_active == TX_IDLE_LEVEL) begin
          byte_done = 1'b1;
          state_d   = HS_SEND;
        end
      end
      default: begin
        state_d = HS_SEND;
      end
    endcase
  end

  // State and start-pulse registers. Leaving HS_SEND the moment the pulse
  // is issued guarantees a single start per byte.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q    <= HS_SEND;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_start = tx_start_q;

endmodule

// File: rtl/sample_dumper.sv
// sample_dumper
// Once a capture is complete, reads the circular sample RAM oldest sample
// first and streams it over the UART as: header byte, 2^SAMPLE_DEPTH sample
// bytes, and optionally an XOR checksum byte. Reading starts half a buffer
// past the trigger address, so the trigger sample lands at index
// 2^(SAMPLE_DEPTH-1) of the sample bytes.
// Optional feature: define SAMPLE_DUMPER_CHECKSUM_EN to append the 8-bit XOR
// of all sample bytes (header excluded) after the last sample.
// Ports:
//   clk_50mhz in  system clock, rising edge
//   reset     in  synchronous, active-high; aborts a frame immediately
//   activate  in  level; starts a dump, must drop before the next one
//   done      out high while the finished frame waits for activate to drop
//   offset    in  trigger address from the sampler, sampled on dump start
//   mem_addr  out RAM read address
//   mem_re    out RAM read enable; data valid one cycle later
//   mem_data  in  RAM read data
//   tx_active in  UART busy
//   tx_start  out one-cycle UART start pulse
//   tx_data   out byte to send, stable from tx_start until tx_active falls
module sample_dumper
  import oscilo_pkg::*;
#(
  parameter int unsigned SAMPLE_DEPTH = 8,
  parameter int unsigned WIDTH        = 8,
  parameter logic [7:0]  HEADER       = HEADER_BYTE
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    activate,
  output logic                    done,
  input  logic [SAMPLE_DEPTH-1:0] offset,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [WIDTH-1:0]        mem_data,
  input  logic                    tx_active,
  output logic                    tx_start,
  output logic [7:0]              tx_data
);

  localparam logic [SAMPLE_DEPTH:0]   NUM_SAMPLES = {1'b1, {SAMPLE_DEPTH{1'b0}}};
  localparam logic [SAMPLE_DEPTH-1:0] HALF_DEPTH  = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
  localparam logic [SAMPLE_DEPTH:0]   CNT_ONE     = {{SAMPLE_DEPTH{1'b0}}, 1'b1};

  dumper_state_t           state_q, state_d;
  logic [SAMPLE_DEPTH-1:0] start_q, start_d;
  logic [SAMPLE_DEPTH:0]   cnt_q, cnt_d;
  logic [SAMPLE_DEPTH-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_re_q, mem_re_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    done_q, done_d;
  logic [7:0]              sample_byte;
  logic                    byte_valid;
  logic                    byte_done;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
  logic                    csum_sent_q, csum_sent_d;
`endif

  // The handshake block runs its own SEND/WBUSY/WDONE sequence; the
  // sequencer simply sits in ST_SEND until the byte is finished.
  assign byte_valid = (state_q == ST_SEND);

  uart_byte_tx_hs u_hs (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .byte_valid(byte_valid),
    .tx_active (tx_active),
    .tx_start  (tx_start),
    .byte_done (byte_done)
  );

  // Sequencer next-state logic. cnt is one bit wider than the address so
  // the "all samples sent" value is representable; address sums wrap
  // naturally at SAMPLE_DEPTH bits. The read is issued on the transition
  // into ST_RD so mem_re is high during ST_RD and the data is present in
  // ST_LAT. When the UART finishes a byte, the next step is chosen here:
  // another sample, the checksum, or the end of the frame.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    tx_data_d   = tx_data_q;
    sample_byte = '0;
    sample_byte[WIDTH-1:0] = mem_data;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
    csum_d      = csum_q;
    csum_sent_d = csum_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (activate) begin
          start_d = offset + HALF_DEPTH;
          cnt_d   = '0;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
          csum_d      = '0;
          csum_sent_d = 1'b0;
`endif
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_data_d = HEADER;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (byte_done) begin
          if (cnt_q < NUM_SAMPLES) begin
            state_d    = ST_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = start_q + cnt_q[SAMPLE_DEPTH-1:0];
          end
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
          else if (!csum_sent_q) begin
            state_d = ST_CSUM;
          end
`endif
          else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        state_d = ST_LAT;
      end
      ST_LAT: begin
        tx_data_d = sample_byte;
        cnt_d     = cnt_q + CNT_ONE;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
        csum_d    = csum_q ^ sample_byte;
`endif
        state_d   = ST_SEND;
      end
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
      ST_CSUM: begin
        tx_data_d   = csum_q;
        csum_sent_d = 1'b1;
        state_d     = ST_SEND;
      end
`endif
      ST_DONE: begin
        if (!activate) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Sequencer registers. All outputs are registered; done follows the
  // next state so it is high exactly while the FSM sits in ST_DONE.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      tx_data_q   <= HEADER;
      done_q      <= 1'b0;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
`ifdef SAMPLE_DUMPER_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_re   = mem_re_q;
  assign tx_data  = tx_data_q;
  assign done     = done_q;

endmodule
